// File: rtl/sum_accumulator_if.sv
// Sample/result handshake bundle between the upstream adder, the batch
// accumulator and its downstream consumer.
interface sum_accumulator_if #(
   parameter int W = 32
);
   logic           in_valid;
   logic [W:0]     in_sum;
   logic           in_odd;
   logic           in_ready;
   logic           clear;
   logic           out_valid;
   logic           out_ready;
   logic [W+4:0]   out_total;
   logic [4:0]     out_odd_cnt;
   logic [W:0]     out_max;
   logic           out_err;

   modport master (
      output in_valid, in_sum, in_odd, clear, out_ready,
      input  in_ready, out_valid, out_total, out_odd_cnt, out_max, out_err
   );

   modport slave (
      input  in_valid, in_sum, in_odd, clear, out_ready,
      output in_ready, out_valid, out_total, out_odd_cnt, out_max, out_err
   );
endinterface

// File: rtl/sum_accumulator.sv
// Collects N adder sum samples into one batch result (total, odd count,
// unsigned maximum, parity-consistency error) and holds it until taken.
module sum_accumulator #(
   parameter int W = 32,
   parameter int N = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   sum_accumulator_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   localparam logic [4:0] N_CNT = 5'(N);

   state_t         state, state_next;
   logic           accept;
   logic           release_res;
   logic           last_sample;
   logic [W+4:0]   total_p0;
   logic [4:0]     odd_cnt_p0;
   logic [W:0]     max_p0;
   logic           err_p0;
   logic [4:0]     count_p0;

   assign accept      = bus.in_valid && bus.in_ready;
   assign release_res = (state == DONE) && bus.out_ready;
   assign last_sample = (count_p0 + 5'd1) == N_CNT;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = last_sample ? DONE : ACCUM;
         ACCUM:   if (accept && last_sample) state_next = DONE;
         DONE:    if (bus.out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
      // Abort wins over any accept or result handshake on the same edge.
      if (bus.clear) state_next = IDLE;
   end

   always_comb begin
      bus.in_ready  = (state != DONE);
      bus.out_valid = (state == DONE);
   end

   // Accumulator stage: results are registered, visible one cycle after accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         total_p0   <= '0;
         odd_cnt_p0 <= '0;
         max_p0     <= '0;
         err_p0     <= 1'b0;
         count_p0   <= '0;
      end else if (bus.clear || release_res) begin
         total_p0   <= '0;
         odd_cnt_p0 <= '0;
         max_p0     <= '0;
         err_p0     <= 1'b0;
         count_p0   <= '0;
      end else if (accept) begin
         total_p0   <= total_p0 + {4'b0, bus.in_sum};
         odd_cnt_p0 <= odd_cnt_p0 + {4'b0, bus.in_odd};
         if (count_p0 == 5'd0 || bus.in_sum > max_p0) max_p0 <= bus.in_sum;
         err_p0     <= err_p0 | (bus.in_odd != bus.in_sum[0]);
         count_p0   <= count_p0 + 5'd1;
      end
   end

   assign bus.out_total   = total_p0;
   assign bus.out_odd_cnt = odd_cnt_p0;
   assign bus.out_max     = max_p0;
   assign bus.out_err     = err_p0;

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed, table-driven bench for sum_accumulator (N=4 build plus an N=1 build).
module tb_sum_accumulator;
   localparam int W = 32;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   sum_accumulator_if #(.W(W)) bus  ();
   sum_accumulator_if #(.W(W)) bus1 ();

   sum_accumulator #(.W(W), .N(4)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
   sum_accumulator #(.W(W), .N(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [3:0][32:0] s;
      logic [3:0]       odd;
      logic             gap;
      logic [36:0]      tot;
      logic [4:0]       oc;
      logic [32:0]      mx;
      logic             e;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_res(input string tag, input logic v, input logic [36:0] tot,
                          input logic [4:0] oc, input logic [32:0] mx, input logic e);
      check({tag, ".out_valid"}, 64'(bus.out_valid),   64'(v));
      check({tag, ".in_ready"},  64'(bus.in_ready),    64'(!v));
      check({tag, ".total"},     64'(bus.out_total),   64'(tot));
      check({tag, ".odd_cnt"},   64'(bus.out_odd_cnt), 64'(oc));
      check({tag, ".max"},       64'(bus.out_max),     64'(mx));
      check({tag, ".err"},       64'(bus.out_err),     64'(e));
   endtask

   task automatic send(input logic [32:0] s, input logic o);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_sum   = s;
      bus.in_odd   = o;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
   endtask

   task automatic handshake(input string tag);
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
      @(negedge clk);
      chk_res(tag, 1'b0, 37'd0, 5'd0, 33'd0, 1'b0);
   endtask

   initial begin
      // batch of four samples, expected total/odd_cnt/max/err
      vecs[0] = '{s: {33'd6, 33'd4, 33'd11, 33'd2}, odd: 4'b0010, gap: 1'b0,
                  tot: 37'd23, oc: 5'd1, mx: 33'd11, e: 1'b0};
      vecs[1] = '{s: {4{33'h1_FFFF_FFFF}}, odd: 4'b1111, gap: 1'b0,
                  tot: 37'h7_FFFF_FFFC, oc: 5'd4, mx: 33'h1_FFFF_FFFF, e: 1'b0};
      vecs[2] = '{s: {33'd0, 33'd5, 33'd4, 33'd3}, odd: 4'b0111, gap: 1'b1,
                  tot: 37'd12, oc: 5'd3, mx: 33'd5, e: 1'b1};
      vecs[3] = '{s: {4{33'd0}}, odd: 4'b0000, gap: 1'b0,
                  tot: 37'd0, oc: 5'd0, mx: 33'd0, e: 1'b0};
      vecs[4] = '{s: {33'd7, 33'd100, 33'd1, 33'd9}, odd: 4'b1001, gap: 1'b1,
                  tot: 37'd117, oc: 5'd2, mx: 33'd100, e: 1'b1};
      vecs[5] = '{s: {33'd3, 33'd2, 33'd1, 33'h1_0000_0000}, odd: 4'b1010, gap: 1'b0,
                  tot: 37'h1_0000_0006, oc: 5'd2, mx: 33'h1_0000_0000, e: 1'b0};

      bus.in_valid = 1'b0; bus.in_sum = '0; bus.in_odd = 1'b0;
      bus.clear = 1'b0;    bus.out_ready = 1'b0;
      bus1.in_valid = 1'b0; bus1.in_sum = '0; bus1.in_odd = 1'b0;
      bus1.clear = 1'b0;    bus1.out_ready = 1'b0;
      rst_n = 1'b0;

      #2 chk_res("reset", 1'b0, 37'd0, 5'd0, 33'd0, 1'b0);
      #10 rst_n = 1'b1;

      for (int v = 0; v < 6; v++) begin
         for (int i = 0; i < 4; i++) begin
            send(vecs[v].s[i], vecs[v].odd[i]);
            if (vecs[v].gap && i < 3) begin
               @(negedge clk);
               check($sformatf("vec%0d.mid%0d.out_valid", v, i), 64'(bus.out_valid), 64'd0);
               check($sformatf("vec%0d.mid%0d.in_ready", v, i), 64'(bus.in_ready), 64'd1);
            end
         end
         @(negedge clk);
         chk_res($sformatf("vec%0d", v), 1'b1, vecs[v].tot, vecs[v].oc, vecs[v].mx, vecs[v].e);
         if (v == 0) begin
            // downstream stalls while upstream keeps offering a sample
            bus.in_valid = 1'b1; bus.in_sum = 33'd77; bus.in_odd = 1'b1;
            for (int k = 0; k < 5; k++) begin
               @(negedge clk);
               chk_res($sformatf("stall%0d", k), 1'b1, 37'd23, 5'd1, 33'd11, 1'b0);
            end
            bus.in_valid = 1'b0;
         end
         handshake($sformatf("vec%0d.hs", v));
      end

      // abort after two samples, with a sample offered on the same edge
      send(33'd5, 1'b1);
      send(33'd6, 1'b0);
      @(negedge clk);
      bus.in_valid = 1'b1; bus.in_sum = 33'd7; bus.in_odd = 1'b1; bus.clear = 1'b1;
      @(posedge clk);
      #1 begin bus.in_valid = 1'b0; bus.clear = 1'b0; end
      @(negedge clk);
      chk_res("clear", 1'b0, 37'd0, 5'd0, 33'd0, 1'b0);
      send(33'd1, 1'b1);
      send(33'd2, 1'b0);
      send(33'd3, 1'b1);
      @(negedge clk);
      check("clear.after3.out_valid", 64'(bus.out_valid), 64'd0);
      send(33'd4, 1'b0);
      @(negedge clk);
      chk_res("clear.fresh", 1'b1, 37'd10, 5'd2, 33'd4, 1'b0);
      handshake("clear.hs");

      // short asynchronous reset pulse with three samples held
      send(33'd10, 1'b0);
      send(33'd20, 1'b0);
      send(33'd30, 1'b0);
      @(negedge clk);
      chk_res("pre_rst", 1'b0, 37'd60, 5'd0, 33'd30, 1'b0);
      #2 rst_n = 1'b0;
      #1 chk_res("async_rst", 1'b0, 37'd0, 5'd0, 33'd0, 1'b0);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) send(33'd1, 1'b1);
      @(negedge clk);
      check("post_rst.after3.out_valid", 64'(bus.out_valid), 64'd0);
      send(33'd1, 1'b1);
      @(negedge clk);
      chk_res("post_rst", 1'b1, 37'd4, 5'd4, 33'd1, 1'b0);
      handshake("post_rst.hs");

      // N=1 build: a single accept completes the batch
      @(negedge clk);
      check("n1.idle.in_ready", 64'(bus1.in_ready), 64'd1);
      bus1.in_valid = 1'b1; bus1.in_sum = 33'd9; bus1.in_odd = 1'b1;
      @(posedge clk);
      #1 bus1.in_valid = 1'b0;
      @(negedge clk);
      check("n1.out_valid", 64'(bus1.out_valid),   64'd1);
      check("n1.in_ready",  64'(bus1.in_ready),    64'd0);
      check("n1.total",     64'(bus1.out_total),   64'd9);
      check("n1.odd_cnt",   64'(bus1.out_odd_cnt), 64'd1);
      check("n1.max",       64'(bus1.out_max),     64'd9);
      check("n1.err",       64'(bus1.out_err),     64'd0);
      bus1.out_ready = 1'b1;
      @(posedge clk);
      #1 bus1.out_ready = 1'b0;
      @(negedge clk);
      check("n1.hs.out_valid", 64'(bus1.out_valid), 64'd0);
      check("n1.hs.total",     64'(bus1.out_total), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sum_accumulator.md
SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 Parameter W, default 32: operand width of the upstream adder; input sum is W+1 bits.
REQ-002 Parameter N, default 8: samples per batch; legal range 1..16.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  upstream sum sample present.
REQ-006 in_sum  input  W+1  adder sum (carry in MSB).
REQ-007 in_odd  input  1  adder odd flag accompanying in_sum.
REQ-008 in_ready  output  1  block can accept a sample this cycle.
REQ-009 clear  input  1  synchronous batch abort.
REQ-010 out_valid  output  1  batch result held on outputs.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 out_total  output  W+5  sum of the N accepted in_sum values.
REQ-013 out_odd_cnt  output  5  number of accepted samples with in_odd=1.
REQ-014 out_max  output  W+1  largest accepted in_sum in the batch, unsigned.
REQ-015 out_err  output  1  at least one sample in the batch had in_odd != in_sum[0].

Function
REQ-016 States SHALL be IDLE (no samples held), ACCUM (1..N-1 samples held), DONE (result held).
REQ-017 A sample SHALL be accepted on a rising edge where in_valid=1 and in_ready=1.
REQ-018 in_ready SHALL be 1 in IDLE and ACCUM, 0 in DONE; combinational from state only.
REQ-019 On accept: total += in_sum (zero-extended to W+5); odd_cnt += in_odd; max = in_sum if in_sum > max (first sample always loads max); err |= (in_odd != in_sum[0]); count += 1.
REQ-020 IDLE -> ACCUM on accept when N>1; IDLE -> DONE on accept when N=1.
REQ-021 ACCUM -> DONE on the accept that makes count equal N; otherwise stays ACCUM.
REQ-022 out_valid SHALL be 1 exactly when state is DONE; result visible the cycle after the N-th accept (latency 1).
REQ-023 out_total, out_odd_cnt, out_max, out_err SHALL be stable while out_valid=1 and not out_ready.
REQ-024 DONE -> IDLE on a rising edge with out_ready=1; total, odd_cnt, max, err, count cleared in the same edge.
REQ-025 in_valid gaps (in_valid=0) in ACCUM SHALL hold all state unchanged; no timeout.
REQ-026 Arithmetic SHALL never overflow: N<=16 guarantees total < 2^(W+5); no saturation logic.
REQ-027 clear=1 SHALL force IDLE and zero all accumulators on that edge, from any state, overriding accept and out_ready in the same cycle.
REQ-028 Outputs out_total/out_odd_cnt/out_max/out_err SHALL read the live accumulators in all states; only their DONE values are meaningful.
REQ-029 Back-to-back batches: first sample of the next batch is accepted no earlier than the cycle after out_ready handshake (one idle bubble minimum is not required beyond that edge).

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE, in_ready=1, out_valid=0, out_total=0, out_odd_cnt=0, out_max=0, out_err=0, count=0, independent of clk.
REQ-031 Reset asserted mid-batch or in DONE SHALL discard the partial/held result; first edge after deassertion behaves as IDLE.

Verification (W=32, N=4 unless stated)
REQ-032 Accept sums 2,11,4,6 with in_odd 0,1,0,0 on consecutive cycles -> next cycle out_valid=1, out_total=23, out_odd_cnt=1, out_max=11, out_err=0, in_ready=0.
REQ-033 Hold out_ready=0 for 5 cycles after out_valid, drive in_valid=1 -> no accept, outputs unchanged; then out_ready=1 -> IDLE, outputs 0, in_ready=1.
REQ-034 Four samples of 0x1_FFFF_FFFF -> out_total=0x7_FFFF_FFFC, out_max=0x1_FFFF_FFFF, no wrap.
REQ-035 Sample in_sum=4 with in_odd=1 within a batch -> out_err=1 at DONE; cleared after handshake.
REQ-036 Two samples accepted, then clear=1 with in_valid=1 same cycle -> IDLE, total=0, sample not counted; next 4 samples form a full fresh batch.
REQ-037 rst_n pulsed low for less than a clock period while in ACCUM with 3 samples -> all outputs 0 immediately; N=1 build: single accept yields out_valid next cycle.
